// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: records retired-instruction trace records into a
// first-word-fall-through FIFO while armed. It stops on a PC-match trigger
// and counts the records it drops while the FIFO is full.
module trace_capture_buffer #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     trc_valid,
   input  logic [XLEN-1:0]          trc_pc,
   input  logic [XLEN-1:0]          trc_instr,
   input  logic [XLEN-1:0]          trc_alu,
   input  logic                     arm,
   input  logic                     flush,
   input  logic                     halt_en,
   input  logic [XLEN-1:0]          halt_pc,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [XLEN-1:0]          rd_instr,
   output logic [XLEN-1:0]          rd_alu,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              ovf_cnt,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STOPPED = 2'd2
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [15:0]     r_ovf;

   logic [XLEN-1:0] r_mem_pc    [DEPTH];
   logic [XLEN-1:0] r_mem_instr [DEPTH];
   logic [XLEN-1:0] r_mem_alu   [DEPTH];

   logic w_push_req;
   logic w_pop;
   logic w_full;
   logic w_push;
   logic w_drop;
   logic w_trigger;

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign w_push_req = (r_state == ST_CAPTURE) && trc_valid;
   assign w_pop      = (r_count != '0) && rd_ready;
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && !w_push;
   assign w_trigger  = w_push_req && halt_en && (trc_pc == halt_pc);

   // Storage write. Flush resets the pointers, so a write that lands in the
   // same cycle as a flush is simply never read.
   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem_pc[r_wptr]    <= trc_pc;
         r_mem_instr[r_wptr] <= trc_instr;
         r_mem_alu[r_wptr]   <= trc_alu;
      end
   end

   // Control FSM, pointers, occupancy and overflow counter. Priority is
   // reset, then flush, then normal operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= '0;
      end else if (flush) begin
         r_state <= ST_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= '0;
      end else begin
         case (r_state)
            ST_IDLE:    if (arm)       r_state <= ST_CAPTURE;
            ST_CAPTURE: if (w_trigger) r_state <= ST_STOPPED;
            ST_STOPPED: if (arm)       r_state <= ST_CAPTURE;
            default:                   r_state <= ST_IDLE;
         endcase
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CW'(1);
         if (w_drop && (r_ovf != 16'hFFFF))
            r_ovf <= r_ovf + 16'd1;
      end
   end

   // The head entry falls through combinationally. The fields read as zero
   // while empty, so stale storage is never visible after reset.
   assign rd_valid = (r_count != '0);
   assign rd_pc    = rd_valid ? r_mem_pc[r_rptr]    : '0;
   assign rd_instr = rd_valid ? r_mem_instr[r_rptr] : '0;
   assign rd_alu   = rd_valid ? r_mem_alu[r_rptr]   : '0;
   assign count    = r_count;
   assign ovf_cnt  = r_ovf;
   assign state    = r_state;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: basic capture and drain,
// overflow, full FIFO with a same-cycle push and pop, trigger stop and
// resume, flush, reset, and the idle-ignore case.
module tb_trace_capture_buffer;

   localparam int DEPTH = 16;
   localparam int XLEN  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              trc_valid;
   logic [XLEN-1:0]   trc_pc, trc_instr, trc_alu;
   logic              arm, flush, halt_en;
   logic [XLEN-1:0]   halt_pc;
   logic              rd_ready;
   logic              rd_valid;
   logic [XLEN-1:0]   rd_pc, rd_instr, rd_alu;
   logic [4:0]        count;
   logic [15:0]       ovf_cnt;
   logic [1:0]        state;

   int n_tests = 0;
   int n_fail  = 0;

   trace_capture_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .trc_valid(trc_valid), .trc_pc(trc_pc),
      .trc_instr(trc_instr), .trc_alu(trc_alu), .arm(arm), .flush(flush),
      .halt_en(halt_en), .halt_pc(halt_pc), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu),
      .count(count), .ovf_cnt(ovf_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Advance one clock edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rec(input logic [31:0] pc);
      trc_pc    = pc;
      trc_instr = ~pc;
      trc_alu   = pc + 32'd1;
   endtask

   task automatic push(input logic [31:0] pc);
      trc_valid = 1'b1;
      set_rec(pc);
      tick();
      trc_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1; tick(); flush = 1'b0;
   endtask

   // Linear sequence of directed steps
   initial begin
      rst_n = 1'b0; trc_valid = 1'b0; trc_pc = '0; trc_instr = '0; trc_alu = '0;
      arm = 1'b0; flush = 1'b0; halt_en = 1'b0; halt_pc = '0; rd_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(ovf_cnt), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_pc", rd_pc, 32'd0);

      // Records offered in IDLE are ignored
      for (int i = 0; i < 10; i++) push(32'(i * 4));
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_ovf", 32'(ovf_cnt), 32'd0);
      chk("idle_state", 32'(state), 32'd0);

      // A pop request on an empty FIFO does nothing
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      chk("empty_pop_count", 32'(count), 32'd0);

      // Basic capture, then drain
      pulse_arm();
      chk("arm_state", 32'(state), 32'd1);
      push(32'h0); push(32'h4); push(32'h8);
      chk("basic_count", 32'(count), 32'd3);
      chk("basic_head_pc", rd_pc, 32'h0);
      chk("basic_head_instr", rd_instr, 32'hFFFF_FFFF);
      chk("basic_head_alu", rd_alu, 32'h1);
      pulse_arm();
      chk("arm_noop_state", 32'(state), 32'd1);
      chk("arm_noop_count", 32'(count), 32'd3);
      rd_ready = 1'b1;
      chk("drain0", rd_pc, 32'h0); tick();
      chk("drain1", rd_pc, 32'h4); tick();
      chk("drain2", rd_pc, 32'h8); tick();
      rd_ready = 1'b0;
      chk("drain_empty", 32'(rd_valid), 32'd0);
      chk("drain_count", 32'(count), 32'd0);

      // Overflow: 20 records into 16 entries
      for (int i = 0; i < 20; i++) push(32'h100 + 32'(i * 4));
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_cnt", 32'(ovf_cnt), 32'd4);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_drain%0d", i), rd_pc, 32'h100 + 32'(i * 4));
         tick();
      end
      rd_ready = 1'b0;
      chk("ovf_drained", 32'(rd_valid), 32'd0);

      // Full FIFO with a push and a pop in the same cycle
      for (int i = 0; i < 16; i++) push(32'h300 + 32'(i * 4));
      chk("full_count", 32'(count), 32'd16);
      chk("full_ovf", 32'(ovf_cnt), 32'd4);
      trc_valid = 1'b1; set_rec(32'h400); rd_ready = 1'b1;
      tick();
      trc_valid = 1'b0;
      chk("simul_count", 32'(count), 32'd16);
      chk("simul_ovf", 32'(ovf_cnt), 32'd4);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("simul_drain%0d", i), rd_pc, 32'h304 + 32'(i * 4));
         tick();
      end
      chk("simul_tail_pc", rd_pc, 32'h400);
      chk("simul_tail_alu", rd_alu, 32'h401);
      tick();
      rd_ready = 1'b0;
      chk("simul_empty", 32'(rd_valid), 32'd0);

      // Flush clears the overflow count and returns to IDLE
      pulse_flush();
      chk("flush_ovf", 32'(ovf_cnt), 32'd0);
      chk("flush_state", 32'(state), 32'd0);

      // Trigger on PC 0x10
      halt_en = 1'b1; halt_pc = 32'h10;
      pulse_arm();
      push(32'h8); push(32'hC);
      chk("pre_trig_state", 32'(state), 32'd1);
      push(32'h10);
      chk("trig_state", 32'(state), 32'd2);
      chk("trig_count", 32'(count), 32'd3);
      push(32'h14);
      chk("stopped_count", 32'(count), 32'd3);
      chk("stopped_ovf", 32'(ovf_cnt), 32'd0);
      chk("stopped_head", rd_pc, 32'h8);
      pulse_arm();
      chk("resume_state", 32'(state), 32'd1);
      chk("resume_count", 32'(count), 32'd3);
      halt_en = 1'b0;

      // Flush takes priority over arm, push and pop in the same cycle
      pulse_flush();
      pulse_arm();
      for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4));
      chk("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1; arm = 1'b1; rd_ready = 1'b1; trc_valid = 1'b1; set_rec(32'h600);
      tick();
      flush = 1'b0; arm = 1'b0; rd_ready = 1'b0; trc_valid = 1'b0;
      chk("flush_pri_count", 32'(count), 32'd0);
      chk("flush_pri_ovf", 32'(ovf_cnt), 32'd0);
      chk("flush_pri_state", 32'(state), 32'd0);
      chk("flush_pri_valid", 32'(rd_valid), 32'd0);

      // Reset mid-capture, with the overflow count nonzero
      pulse_arm();
      for (int i = 0; i < 17; i++) push(32'h700 + 32'(i * 4));
      chk("pre_rst_ovf", 32'(ovf_cnt), 32'd1);
      rst_n = 1'b0; trc_valid = 1'b1; rd_ready = 1'b1; arm = 1'b1;
      tick();
      rst_n = 1'b1; trc_valid = 1'b0; rd_ready = 1'b0; arm = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_rd_pc", rd_pc, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
